// File: rtl/fwd_scoreboard.sv
// Purpose : EX-stage forwarding/hazard scoreboard over the DEPTH stages after EX (stage 0 = MEM).
// Latency : operand lookup is combinational; producers enter stage 0 on the edge after EX.
// Backpr. : raises stall on a load-use hazard (EX repeats); pipe_hold freezes every entry.
//
// Ports:
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   pipe_hold                  global freeze, scoreboard does not shift
//   ex_valid/ex_wr_en/ex_rd    EX instruction presence, register write, destination
//   ex_result/ex_is_load       EX ALU result; load flag (result is only an address)
//   ex_rs_a/ex_rs_b            EX source registers
//   rf_data_a/rf_data_b        register-file read values for the sources
//   mem_ld_data                load data belonging to the stage-0 entry this cycle
//   opa/opb, sel_a/sel_b       forwarded operands; sel 0 = regfile, k = stage k-1
//   stall                      load-use hazard, hold IF/ID/EX this cycle
//   fwd_cnt/stall_cnt          saturating statistics, present only with FWD_STATS_EN
module fwd_scoreboard #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int DEPTH  = 2,
   parameter int SEL_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pipe_hold,
   input  logic              ex_valid,
   input  logic              ex_wr_en,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [DATA_W-1:0] ex_result,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_rs_a,
   input  logic [REG_AW-1:0] ex_rs_b,
   input  logic [DATA_W-1:0] rf_data_a,
   input  logic [DATA_W-1:0] rf_data_b,
   input  logic [DATA_W-1:0] mem_ld_data,
   output logic [DATA_W-1:0] opa,
   output logic [DATA_W-1:0] opb,
   output logic [SEL_W-1:0]  sel_a,
   output logic [SEL_W-1:0]  sel_b,
   output logic              stall
`ifdef FWD_STATS_EN
   ,
   output logic [31:0]       fwd_cnt,
   output logic [31:0]       stall_cnt
`endif
);

   logic              entValid [DEPTH];
   logic [REG_AW-1:0] entRd    [DEPTH];
   logic [DATA_W-1:0] entData  [DEPTH];
   logic              entReady [DEPTH];

   logic              hitA, hitB, rdyA, rdyB;
   logic [DATA_W-1:0] dataA, dataB;
   logic [SEL_W-1:0]  idxA, idxB;
   logic [SEL_W-1:0]  selA, selB;

   // Walk from oldest to youngest so the lowest-index match overwrites the rest.
   always_comb begin
      hitA  = 1'b0;
      rdyA  = 1'b0;
      dataA = '0;
      idxA  = '0;
      hitB  = 1'b0;
      rdyB  = 1'b0;
      dataB = '0;
      idxB  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (entValid[i] && entRd[i] == ex_rs_a && ex_rs_a != '0) begin
            hitA  = 1'b1;
            rdyA  = entReady[i];
            dataA = entData[i];
            idxA  = SEL_W'(i + 1);
         end
         if (entValid[i] && entRd[i] == ex_rs_b && ex_rs_b != '0) begin
            hitB  = 1'b1;
            rdyB  = entReady[i];
            dataB = entData[i];
            idxB  = SEL_W'(i + 1);
         end
      end
   end

   // A non-ready youngest match is never bypassed by an older ready one.
   assign selA  = (hitA && rdyA) ? idxA : '0;
   assign selB  = (hitB && rdyB) ? idxB : '0;
   assign opa   = (hitA && rdyA) ? dataA : rf_data_a;
   assign opb   = (hitB && rdyB) ? dataB : rf_data_b;
   assign sel_a = selA;
   assign sel_b = selB;
   assign stall = ex_valid && ((hitA && !rdyA) || (hitB && !rdyB));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            entValid[i] <= 1'b0;
            entRd[i]    <= '0;
            entData[i]  <= '0;
            entReady[i] <= 1'b0;
         end
      end else if (!pipe_hold) begin
         // Only stage 0 can hold a pending load; it picks up its data while
         // moving to stage 1, so every entry from stage 1 on is ready.
         for (int k = DEPTH - 1; k >= 1; k--) begin
            entValid[k] <= entValid[k-1];
            entRd[k]    <= entRd[k-1];
            entReady[k] <= 1'b1;
            if (k == 1 && !entReady[0])
               entData[k] <= mem_ld_data;
            else
               entData[k] <= entData[k-1];
         end
         // A stalled EX instruction repeats next cycle, so a bubble goes in now.
         entValid[0] <= ex_valid && ex_wr_en && !stall;
         entRd[0]    <= ex_rd;
         entData[0]  <= ex_result;
         entReady[0] <= !ex_is_load;
      end
   end

`ifdef FWD_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_cnt   <= '0;
         stall_cnt <= '0;
      end else if (!pipe_hold) begin
         if (ex_valid && !stall && (selA != '0 || selB != '0) && fwd_cnt != '1)
            fwd_cnt <= fwd_cnt + 32'd1;
         if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
